// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: constant log2 and parameter legality checks.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Ratio must be an integral power of two >= 2 so lanes map onto pointer LSBs.
  function automatic bit params_ok(input int unsigned in_w, input int unsigned out_w,
                                   input int unsigned depth);
    return (in_w != 0) && (out_w % in_w == 0) && (out_w / in_w >= 2) &&
           is_pow2(out_w / in_w) && is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/narrow_to_wide_fifo_mem.sv
// Simple dual-port RAM, DEPTH x (LANES*IN_WIDTH), per-lane write enables, async read.
module narrow_to_wide_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 4,
  parameter int unsigned LANES    = 2,
  parameter int unsigned DEPTH    = 32
) (
  input  logic                          clk,
  input  logic [LANES-1:0]              we,
  input  logic [clog2(DEPTH)-1:0]       waddr,
  input  logic [IN_WIDTH-1:0]           wdata,
  input  logic [clog2(DEPTH)-1:0]       raddr,
  output logic [IN_WIDTH*LANES-1:0]     rdata
);

  logic [IN_WIDTH*LANES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we[i]) mem[waddr][i*IN_WIDTH +: IN_WIDTH] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/narrow_to_wide_fifo.sv
// Gathering FWFT FIFO: packs OUT_WIDTH/IN_WIDTH narrow words little-endian into wide words.
// Define NARROW_TO_WIDE_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module narrow_to_wide_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned DEPTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [IN_WIDTH-1:0]  d,
  output logic [OUT_WIDTH-1:0] q,
  output logic                 full,
  output logic                 empty
`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int unsigned R  = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned LW = clog2(R);
  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + LW;
  localparam logic [PW:0] CAP    = (PW+1)'(DEPTH * R);
  localparam logic [PW:0] R_FILL = (PW+1)'(R);

  if (!params_ok(IN_WIDTH, OUT_WIDTH, DEPTH)) begin : g_bad_params
    $error("narrow_to_wide_fifo: illegal IN_WIDTH/OUT_WIDTH/DEPTH combination");
  end

  logic [PW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [PW:0]   fill;
  logic          push_ok;
  logic          pop_ok;
  logic [R-1:0]  lane_we;

  // Read pointer scaled to narrow-slot units so fill survives wrap via modular subtract.
  assign fill    = wr_ptr - {rd_ptr, {LW{1'b0}}};
  assign full    = (fill == CAP);
  assign empty   = (fill < R_FILL);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    lane_we = '0;
    if (push_ok) lane_we[wr_ptr[LW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)  overflow  <= 1'b1;
      if (pop & empty)  underflow <= 1'b1;
    end
  end
`endif

  narrow_to_wide_fifo_mem #(
    .IN_WIDTH (IN_WIDTH),
    .LANES    (R),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (lane_we),
    .waddr (wr_ptr[PW-1:LW]),
    .wdata (d),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (q)
  );

endmodule

// File: tb/tb_narrow_to_wide_fifo.sv
// Self-checking bench for narrow_to_wide_fifo (IN=4, OUT=8, DEPTH=32) against a queue model.
module tb_narrow_to_wide_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [3:0] d = '0;
  logic [7:0] q;
  logic       full;
  logic       empty;
`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] model [$];
  bit         m_ovf;
  bit         m_unf;

  narrow_to_wide_fifo #(
    .IN_WIDTH  (4),
    .OUT_WIDTH (8),
    .DEPTH     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .d         (d),
    .q         (q),
    .full      (full),
    .empty     (empty)
`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected flags and head word derived purely from the narrow-word queue.
  task automatic check_model(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(model.size() < 2));
    check({tag, ".full"},  32'(full),  32'(model.size() == 64));
    if (model.size() >= 2) check({tag, ".q"}, 32'(q), 32'({model[1], model[0]}));
`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  task automatic cycle(input bit p, input bit o, input logic [3:0] dd, input string tag);
    bit ap, ao;
    push = p;
    pop  = o;
    d    = dd;
    ap = p && (model.size() < 64);
    ao = o && (model.size() >= 2);
    if (p && model.size() == 64) m_ovf = 1'b1;
    if (o && model.size() < 2)   m_unf = 1'b1;
    @(posedge clk);
    if (ao) begin
      void'(model.pop_front());
      void'(model.pop_front());
    end
    if (ap) model.push_back(dd);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    model.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #100;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full",  32'(full),  32'd0);
  endtask

  typedef struct {
    bit         p;
    bit         o;
    logic [3:0] dd;
    bit         e_empty;
    bit         e_full;
    logic [7:0] e_q;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 8'h21};
    tbl[2]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 8'h21};
    tbl[3]  = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 8'h21};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h43};
    tbl[5]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 8'h65};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 8'h87};

    // Reset and table-driven basic packing.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].p, tbl[i].o, tbl[i].dd, "tbl");
      check("tbl.empty", 32'(empty), 32'(tbl[i].e_empty));
      check("tbl.full",  32'(full),  32'(tbl[i].e_full));
      if (!tbl[i].e_empty) check("tbl.q", 32'(q), 32'(tbl[i].e_q));
    end

    // Fill to capacity, then a dropped push.
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      cycle(1'b1, 1'b0, 4'(i % 16), "fill");
      check("fill.full_const", 32'(full), 32'(i == 64));
      if (i >= 2) check("fill.empty_const", 32'(empty), 32'd0);
    end
    cycle(1'b1, 1'b0, 4'hF, "drop");
    check("drop.full", 32'(full), 32'd1);
    check("drop.q",    32'(q),    32'h21);
`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
    check("drop.overflow", 32'(overflow), 32'd1);
`endif

    // Drain all 32 wide words.
    for (int k = 0; k < 32; k++) begin
      logic [7:0] exp_w;
      exp_w = {4'((2 * k + 2) % 16), 4'((2 * k + 1) % 16)};
      check("drain.q_const", 32'(q), 32'(exp_w));
      cycle(1'b0, 1'b1, 4'h0, "drain");
    end
    check("drained.empty", 32'(empty), 32'd1);
    check("drained.full",  32'(full),  32'd0);
    cycle(1'b0, 1'b1, 4'h0, "extra_pop");
    check("extra_pop.empty", 32'(empty), 32'd1);
`ifdef NARROW_TO_WIDE_FIFO_ERR_EN
    check("extra_pop.underflow", 32'(underflow), 32'd1);
`endif

    // Simultaneous push/pop starting near full, across pointer wrap.
    do_reset();
    for (int i = 0; i < 62; i++) cycle(1'b1, 1'b0, 4'($urandom), "pre62");
    check("pre62.size", 32'(model.size()), 32'd62);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 4'hA, "pushpop");

    // Randomized traffic, push-heavy then pop-heavy.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit p, o;
      if (i < 300) begin
        p = ($urandom % 4) != 0;
        o = ($urandom % 4) == 0;
      end else begin
        p = ($urandom % 4) == 0;
        o = ($urandom % 3) != 0;
      end
      cycle(p, o, 4'($urandom), "rand");
    end

    // Asynchronous reset mid-cycle discards a partial word.
    do_reset();
    cycle(1'b1, 1'b0, 4'h7, "partial");
    cycle(1'b1, 1'b0, 4'h9, "partial2");
    rst = 1'b0;
    #1;
    check("async_rst.empty", 32'(empty), 32'd1);
    check("async_rst.full",  32'(full),  32'd0);
    model.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 4'h7, "post_rst0");
    rst = 1'b0;
    #1;
    check("mid_rst.empty", 32'(empty), 32'd1);
    model.delete();
    #1;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 4'h1, "post_rst1");
    check("post_rst1.empty", 32'(empty), 32'd1);
    cycle(1'b1, 1'b0, 4'h2, "post_rst2");
    check("post_rst2.empty", 32'(empty), 32'd0);
    check("post_rst2.q",     32'(q),     32'h21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
